// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with NUM_RD registered read ports,
// one write port and a hardware clear sequencer that zeroes the array one
// entry per cycle.
// Optional feature macro: REGFILE_BYPASS_EN enables same-edge write-to-read
// forwarding; without it a same-edge read returns the old entry value.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_val [NUM_RD];
  logic                wr_ok;

  // Writes land only in IDLE and never on a hardwired zero entry.
  assign wr_ok = wr_en && (state == S_IDLE) &&
                 !((ZERO_REG != 0) && (wr_addr == '0));

  assign busy = (state == S_CLEAR);

  // State and sweep index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: clr_req starts the sweep, which ends after clearing the last entry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt = S_CLEAR;
          idx_nxt   = '0;
        end
      end
      S_CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (idx == '1) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Storage array: reset zeroes everything, the sweep clears one entry per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (state == S_CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port read value; the zero-register rule overrides any forwarded data.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_val[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_val[p] = wr_data;
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
        rd_val[p] = '0;
      end
    end
  end

  // Registered read ports; a port holds its data while its strobe is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= rd_val[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance (64-bit, 32 entries, 2 ports,
// zero register) and a small instance (16-bit, 8 entries, 4 ports, no zero
// register), each compared every cycle against an array model.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic [1:0]   rd_en_a = '0;
  logic [9:0]   rd_addr_a = '0;
  logic [127:0] rd_data_a;
  logic         wr_en_a = 1'b0;
  logic [4:0]   wr_addr_a = '0;
  logic [63:0]  wr_data_a = '0;
  logic         clr_a = 1'b0;
  logic         busy_a;

  // Instance B signals
  logic [3:0]   rd_en_b = '0;
  logic [11:0]  rd_addr_b = '0;
  logic [63:0]  rd_data_b;
  logic         wr_en_b = 1'b0;
  logic [2:0]   wr_addr_b = '0;
  logic [15:0]  wr_data_b = '0;
  logic         clr_b = 1'b0;
  logic         busy_b;

  regfile_param #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .clr_req(clr_a), .busy(busy_a));

  regfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .clr_req(clr_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference models ----------------
  logic [63:0] m_a [32];
  logic [63:0] exp_a [2];
  bit          busy_ma;
  int          swp_a;

  logic [15:0] m_b [8];
  logic [15:0] exp_b [4];
  bit          busy_mb;
  int          swp_b;

  function automatic logic [63:0] read_a(input logic [4:0] ad);
    if (ad == 5'd0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_a && !busy_ma && wr_addr_a == ad) return wr_data_a;
`endif
    return m_a[ad];
  endfunction

  function automatic logic [15:0] read_b(input logic [2:0] ad);
`ifdef REGFILE_BYPASS_EN
    if (wr_en_b && !busy_mb && wr_addr_b == ad) return wr_data_b;
`endif
    return m_b[ad];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 32; k++) m_a[k] <= '0;
      for (int p = 0; p < 2; p++) exp_a[p] <= '0;
      busy_ma <= 1'b0;
      swp_a   <= 0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (rd_en_a[p]) exp_a[p] <= read_a(rd_addr_a[p*5 +: 5]);
      if (busy_ma) begin
        m_a[swp_a] <= '0;
        if (swp_a == 31) begin busy_ma <= 1'b0; swp_a <= 0; end
        else swp_a <= swp_a + 1;
      end else begin
        if (wr_en_a && wr_addr_a != 5'd0) m_a[wr_addr_a] <= wr_data_a;
        if (clr_a) begin busy_ma <= 1'b1; swp_a <= 0; end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) m_b[k] <= '0;
      for (int p = 0; p < 4; p++) exp_b[p] <= '0;
      busy_mb <= 1'b0;
      swp_b   <= 0;
    end else begin
      for (int p = 0; p < 4; p++)
        if (rd_en_b[p]) exp_b[p] <= read_b(rd_addr_b[p*3 +: 3]);
      if (busy_mb) begin
        m_b[swp_b] <= '0;
        if (swp_b == 7) begin busy_mb <= 1'b0; swp_b <= 0; end
        else swp_b <= swp_b + 1;
      end else begin
        if (wr_en_b) m_b[wr_addr_b] <= wr_data_b;
        if (clr_b) begin busy_mb <= 1'b1; swp_b <= 0; end
      end
    end
  end

  // Per-cycle comparison of every output against the models.
  always @(negedge clk) begin
    if (checking) begin
      for (int p = 0; p < 2; p++)
        chk($sformatf("rd_a[%0d]", p), rd_data_a[p*64 +: 64], exp_a[p]);
      chk("busy_a", {63'h0, busy_a}, {63'h0, busy_ma});
      for (int p = 0; p < 4; p++)
        chk($sformatf("rd_b[%0d]", p), {48'h0, rd_data_b[p*16 +: 16]}, {48'h0, exp_b[p]});
      chk("busy_b", {63'h0, busy_b}, {63'h0, busy_mb});
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_en_a = '0; wr_en_a = 1'b0; clr_a = 1'b0;
    rd_en_b = '0; wr_en_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    idle_inputs();
    while ((busy_a || busy_b) && n < 100) begin step(); n++; end
    if (busy_a || busy_b) chk("wait_idle_timeout", {63'h0, busy_a | busy_b}, 64'h0);
  endtask

  task automatic read_all_a();
    for (int a = 0; a < 32; a++) begin
      rd_en_a = 2'b11;
      rd_addr_a = {a[4:0], a[4:0]};
      step();
    end
    rd_en_a = '0;
    step();
  endtask

  task automatic fill_a();
    for (int a = 1; a < 32; a++) begin
      wr_en_a = 1'b1;
      wr_addr_a = a[4:0];
      wr_data_a = {32'hC0DE_0000 | a, $urandom} | 64'h1;
      step();
    end
    wr_en_a = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [4:0] a5;

    // Reset and post-reset reads
    idle_inputs();
    rst = 1'b0;
    checking = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    chk("reset_busy_a", {63'h0, busy_a}, 64'h0);
    chk("reset_rd_a0", rd_data_a[63:0], 64'h0);
    read_all_a();
    chk("reset_read_a1", rd_data_a[127:64], 64'h0);

    // Write then read, and the zero register
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 64'hDEAD_BEEF_0000_0005;
    step();
    wr_en_a = 1'b0; rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd5};
    step();
    rd_en_a = '0;
    chk("write_read_5", rd_data_a[63:0], 64'hDEAD_BEEF_0000_0005);
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 64'h1;
    step();
    wr_en_a = 1'b0; rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd0};
    step();
    rd_en_a = '0;
    chk("zero_reg_p0", rd_data_a[63:0], 64'h0);
    chk("zero_reg_p1", rd_data_a[127:64], 64'h0);

    // Same-edge read and write of address 7 (previously zero)
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 64'h1234;
    rd_en_a = 2'b11; rd_addr_a = {5'd7, 5'd7};
    step();
    idle_inputs();
`ifdef REGFILE_BYPASS_EN
    chk("same_edge_p0", rd_data_a[63:0], 64'h1234);
    chk("same_edge_p1", rd_data_a[127:64], 64'h1234);
`else
    chk("same_edge_p0", rd_data_a[63:0], 64'h0);
    chk("same_edge_p1", rd_data_a[127:64], 64'h0);
`endif

    // Multi-port reads and port hold on instance B
    for (int a = 0; a < 8; a++) begin
      wr_en_b = 1'b1; wr_addr_b = a[2:0]; wr_data_b = 16'hA000 | 16'(a);
      step();
    end
    wr_en_b = 1'b0;
    rd_en_b = 4'hF; rd_addr_b = {3'd5, 3'd0, 3'd7, 3'd2};
    step();
    rd_en_b = 4'h0;
    chk("b_port0", {48'h0, rd_data_b[15:0]},  64'hA002);
    chk("b_port1", {48'h0, rd_data_b[31:16]}, 64'hA007);
    chk("b_port2", {48'h0, rd_data_b[47:32]}, 64'hA000);
    chk("b_port3", {48'h0, rd_data_b[63:48]}, 64'hA005);
    for (int a = 0; a < 8; a++) begin
      wr_en_b = 1'b1; wr_addr_b = a[2:0]; wr_data_b = 16'h5500 | 16'(a);
      rd_addr_b = 12'($urandom);
      step();
    end
    wr_en_b = 1'b0;
    step();
    chk("b_hold", rd_data_b, 64'hA005_A000_A007_A002);

    // Randomized traffic on both instances, occasional clear sweeps
    for (int i = 0; i < 400; i++) begin
      rd_en_a = 2'($urandom); rd_addr_a = 10'($urandom);
      wr_en_a = 1'($urandom); wr_addr_a = 5'($urandom);
      wr_data_a = {$urandom, $urandom};
      clr_a = ($urandom_range(0, 59) == 0);
      rd_en_b = 4'($urandom); rd_addr_b = 12'($urandom);
      wr_en_b = 1'($urandom); wr_addr_b = 3'($urandom);
      wr_data_b = 16'($urandom);
      clr_b = ($urandom_range(0, 29) == 0);
      step();
    end
    wait_idle();

    // Directed clear sweep with a dropped write
    fill_a();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      wr_en_a = (cnt == 5);
      wr_addr_a = 5'd3; wr_data_a = 64'hFFFF_0000_FFFF_0003;
      rd_en_a = 2'($urandom); rd_addr_a = 10'($urandom);
      step();
    end
    idle_inputs();
    chk("sweep_busy_cycles", 64'(cnt), 64'd32);
    read_all_a();
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
    step();
    rd_en_a = '0;
    chk("sweep_dropped_wr3", rd_data_a[63:0], 64'h0);

    // Reset in the middle of a sweep
    fill_a();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2 rst = 1'b0;
    #1 chk("midsweep_busy_async", {63'h0, busy_a}, 64'h0);
    step(); step();
    rst = 1'b1;
    step();
    read_all_a();
    a5 = 5'd17;
    rd_en_a = 2'b10; rd_addr_a = {a5, 5'd0};
    step();
    rd_en_a = '0;
    chk("midsweep_entry17", rd_data_a[127:64], 64'h0);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("new_clr_accepted", {63'h0, busy_a}, 64'h1);
    wait_idle();
    step();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised, multi-read-port register file for the datapath, replacing the fixed 32x64 two-port file. Depth, width and read-port count are parameters. Reads are registered with one-cycle latency and optional write-to-read forwarding. A hardware clear sequencer can zero the whole array without a reset.

## Interface
- `DATA_W`, 64, entry width in bits.
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`.
- `NUM_RD`, 2, number of read ports (1..8).
- `ZERO_REG`, 1, when 1, entry 0 is hardwired to zero.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_en`  in  NUM_RD  per-port read strobe; bit i belongs to port i.
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses; port i is at `[i*ADDR_W +: ADDR_W]`.
- `rd_data`  out  NUM_RD*DATA_W  packed registered read data; port i is at `[i*DATA_W +: DATA_W]`.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `clr_req`  in  1  single-cycle pulse that starts a clear sweep.
- `busy`  out  1  high while a clear sweep is in progress.

## Operation
- **Reset** (`rst`=0, asynchronous):
  - all entries are zeroed;
  - all `rd_data` ports are set to 0;
  - `busy` is 0;
  - the FSM goes to IDLE and the sweep index to 0.
- **FSM states.** There are two states: IDLE and CLEAR.
  - IDLE -> CLEAR on `clr_req`=1.
  - CLEAR writes 0 to entry `idx`, then `idx` increments.
  - CLEAR -> IDLE on the cycle that clears `idx`=DEPTH-1; `idx` returns to 0.
  - `clr_req` is ignored while in CLEAR.
- **busy.** `busy`=1 exactly while in the CLEAR state, which lasts DEPTH cycles.
- **Write.**
  - In IDLE, when `wr_en`=1, `wr_data` is stored at `wr_addr` on the rising edge.
  - If `ZERO_REG`=1, writes to address 0 are discarded.
  - In CLEAR, `wr_en` is ignored (the write is dropped, not queued).
- **Read.** On each rising edge, for every port i with `rd_en[i]`=1, `rd_data` port i loads the entry at `rd_addr` port i. With `rd_en[i]`=0, `rd_data` port i holds its value.
- **Zero register.** If `ZERO_REG`=1, a read of address 0 always returns 0.
- **Same-address reads.** Any number of read ports may name the same address in the same cycle; all return the same data.
- **Reads during CLEAR** return the current array contents; entries not yet swept keep their old values.

## Timing
- **Read latency** is 1 cycle: the address is sampled at edge N and the data is valid after edge N until the next enabled read.
- **Write latency:**
  - the array is updated at edge N;
  - a read sampled at edge N+1 or later sees the new value;
  - a same-edge read is governed by Configuration below.
- **Clear sweep:**
  - `clr_req` sampled at edge N sets `busy` after edge N;
  - entry k is cleared at edge N+1+k;
  - `busy` falls after edge N+DEPTH.
- **Reset mid-sweep** aborts the sweep immediately. `busy` drops asynchronously and the array is fully zeroed by the reset itself.
- **Simultaneous `clr_req` and `wr_en` in IDLE:** the write completes at that edge, then the sweep starts. The sweep later clears that entry as well.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** a read on port i at edge N forwards `wr_data` when all of the following hold:
  - `wr_en`=1 and the FSM is in IDLE;
  - `wr_addr` equals `rd_addr` port i;
  - the address is not the discarded zero register.

  The read then returns the value being written at that edge.
- **`REGFILE_BYPASS_EN` undefined:** the same-edge read returns the old entry value.
- With or without the macro, the zero-register and CLEAR rules take precedence.

## Test plan
- **Reset, then read.** Release reset, then read every address on all ports -> all `rd_data` = 0 and `busy` = 0.
- **Write then read.** Write `64'hDEAD_BEEF_0000_0005` to address 5 at edge N; read address 5 on port 0 at edge N+1 -> `rd_data` port 0 = `64'hDEAD_BEEF_0000_0005` after edge N+1. Write 1 to address 0 and read it back -> 0.
- **Same-edge read and write.** At edge N, write `64'h1234` to address 7 and read address 7 on both ports; address 7 previously held `64'h0` ->
  - with `REGFILE_BYPASS_EN`: both ports = `64'h1234`;
  - without it: both ports = 0.
- **Clear sweep.** Fill entries 1..31 with nonzero values, then pulse `clr_req` ->
  - `busy` is high for exactly 32 cycles;
  - a `wr_en` to address 3 during the sweep is dropped;
  - all reads after the sweep return 0.
- **Reset mid-sweep.** Assert `rst`=0 at sweep entry 10 -> `busy` drops asynchronously. After release, all entries read 0 and a new `clr_req` is accepted.
- **Port hold and multi-port reads.** Parameter set `NUM_RD`=4, `ADDR_W`=3:
  - reads of distinct addresses on all ports return the correct data;
  - with `rd_en` deasserted, the ports hold their data while the array changes.
